// File: rtl/fetch_unit.sv
// fetch_unit
//
// In-order instruction fetch stage feeding the fetch/decode pipeline register.
// Holds the PC, issues word-aligned instruction-memory requests while credits
// are available, buffers in-order responses in a small FIFO and presents
// {pc, instr} beats downstream. A redirect flushes the FIFO, marks every
// in-flight response for discard and restarts fetch at the new address.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   imem_req_valid_o     fetch request to instruction memory
//   imem_req_ready_i     memory accepts the request
//   imem_req_addr_o      word-aligned fetch address (always pc_q)
//   imem_rsp_valid_i     response beat, in request order, never stalled
//   imem_rsp_data_i      instruction word of the response
//   redirect_valid_i     flush and restart fetch
//   redirect_addr_i      restart address (bits [1:0] forced to 0)
//   wr_valid_o           downstream beat valid
//   wr_data_o            {pc, instr}, pc in the upper Width bits
//   wr_ready_i           downstream accepts the beat
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source never withdraws valid or changes data while waiting for
// ready, except that a redirect may drop the request or flush the beat.

module fetch_unit #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] ResetAddr = '0,
    parameter int unsigned      Depth     = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [Width-1:0]   imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [Width-1:0]   imem_rsp_data_i,
    input  logic               redirect_valid_i,
    input  logic [Width-1:0]   redirect_addr_i,
    output logic               wr_valid_o,
    output logic [2*Width-1:0] wr_data_o,
    input  logic               wr_ready_i
);

    localparam int unsigned      CntW   = $clog2(Depth + 1);
    localparam int unsigned      PtrW   = $clog2(Depth);
    localparam logic [CntW:0]    DepthC = (CntW + 1)'(Depth);
    localparam logic [Width-1:0] Step   = Width'(4);

    logic [Width-1:0]   pc_q;
    logic [Width-1:0]   rsp_pc_q;
    logic [CntW-1:0]    outstanding_q;
    logic [CntW-1:0]    drop_q;
    logic [CntW-1:0]    count_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [PtrW-1:0]    wr_ptr_q;
    logic [2*Width-1:0] fifo_q [Depth];

    logic [CntW:0]      credit_used;
    logic [Width-1:0]   redirect_pc;
    logic               req_fire;
    logic               push;
    logic               pop;

    // Every accepted request owns a FIFO slot until its beat is popped, so
    // in-flight plus buffered never exceeds Depth and a push never overflows.
    assign credit_used      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid_o = rst_ni && !redirect_valid_i && (credit_used < DepthC);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign redirect_pc = redirect_addr_i & ~Width'(3);

    // Responses for requests issued before a redirect are still owed by the
    // memory; they are counted in drop_q and swallowed as they arrive.
    assign push = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;

    assign wr_valid_o = (count_q != '0);
    assign wr_data_o  = fifo_q[rd_ptr_q];
    assign pop        = wr_valid_o && wr_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= ResetAddr;
            rsp_pc_q      <= ResetAddr;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid_i);

            if (redirect_valid_i) begin
                pc_q     <= redirect_pc;
                rsp_pc_q <= redirect_pc;
                // outstanding_q already includes responses marked for drop,
                // so the new drop count is simply everything still owed.
                drop_q   <= outstanding_q - CntW'(imem_rsp_valid_i);
                // A pop this cycle is still a real handshake; the flush only
                // discards what remains behind it.
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + Step;
                end
                if (imem_rsp_valid_i && (drop_q != '0)) begin
                    drop_q <= drop_q - CntW'(1);
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + Step;
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                count_q <= count_q + CntW'(push) - CntW'(pop);
            end
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data_i};
        end
    end

    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        push |-> ({1'b0, count_q} != DepthC)
    );

    a_no_spurious_rsp : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//
// Directed bench for fetch_unit (Depth 2, ResetAddr 0xFFFF_FFF8 so the very
// first fetches also cross the top of the address space). A small memory
// model answers every accepted request after a programmable latency with
// ins(addr); each step below states the cycle-exact expected outputs.

module tb_fetch_unit;

    localparam logic [31:0] RST = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    logic        clk_i;
    logic        rst_ni;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_addr_i;
    logic        wr_valid_o;
    logic [63:0] wr_data_o;
    logic        wr_ready_i;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;
    int ecnt     = 0;
    int n_pops   = 0;
    int pops_ref;
    mem_req_t mq[$];

    fetch_unit #(
        .Width    (32),
        .ResetAddr(RST),
        .Depth    (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_addr_i (redirect_addr_i),
        .wr_valid_o      (wr_valid_o),
        .wr_data_o       (wr_data_o),
        .wr_ready_i      (wr_ready_i)
    );

    // ---------------- clock ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] a);
        return {a, ins(a)};
    endfunction

    // ---------------- memory model ----------------
    // Samples the request handshake at the edge, then drives the response
    // that must be seen at the following edge.
    initial begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(posedge clk_i);
            ecnt++;
            if (!rst_ni) begin
                mq.delete();
            end else if (imem_req_valid_o && imem_req_ready_i) begin
                mq.push_back('{addr: imem_req_addr_o, due: ecnt + lat});
            end
            #1;
            if (mq.size() > 0 && mq[0].due == ecnt + 1) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = ins(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
            end
        end
    end

    // Downstream handshake counter.
    initial begin
        forever begin
            @(posedge clk_i);
            if (rst_ni && wr_valid_o && wr_ready_i) n_pops++;
        end
    end

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, ".req_valid"}, 64'(imem_req_valid_o), 64'(v));
        chk({tag, ".req_addr"}, 64'(imem_req_addr_o), 64'(a));
    endtask

    task automatic chk_wr(input string tag, input logic v, input logic [31:0] a);
        chk({tag, ".wr_valid"}, 64'(wr_valid_o), 64'(v));
        if (v) chk({tag, ".wr_data"}, wr_data_o, beat(a));
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_ni           = 1'b0;
        imem_req_ready_i = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_addr_i  = '0;
        wr_ready_i       = 1'b1;

        step(); step();
        chk_req("reset", 1'b0, RST);
        chk_wr("reset", 1'b0, 32'h0);

        // Release reset: first request at ResetAddr in the first cycle.
        step();
        rst_ni = 1'b1;
        #1;
        chk_req("first_req", 1'b1, RST);

        // Streaming with L=1, wrap from 0xFFFF_FFFC to 0.
        step(); chk_req("a0", 1'b1, 32'hFFFF_FFFC); chk_wr("a0", 1'b0, 32'h0);
        step(); chk_req("a1", 1'b0, 32'h0000_0000); chk_wr("a1", 1'b1, RST);
        step(); chk_req("a2", 1'b1, 32'h0000_0000); chk_wr("a2", 1'b1, 32'hFFFF_FFFC);
        step(); chk_req("a3", 1'b1, 32'h0000_0004); chk_wr("a3", 1'b0, 32'h0);
        step(); chk_req("a4", 1'b0, 32'h0000_0008); chk_wr("a4", 1'b1, 32'h0000_0000);

        // Backpressure: FIFO fills, requests stop, head holds.
        wr_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_req("b_hold", 1'b0, 32'h0000_0008);
            chk_wr("b_hold", 1'b1, 32'h0000_0000);
        end
        wr_ready_i = 1'b1;
        step(); chk_req("b1", 1'b1, 32'h0000_0008); chk_wr("b1", 1'b1, 32'h0000_0004);
        step(); chk_req("b2", 1'b1, 32'h0000_000C); chk_wr("b2", 1'b0, 32'h0);
        step(); chk_req("b3", 1'b0, 32'h0000_0010); chk_wr("b3", 1'b1, 32'h0000_0008);

        // Fill the FIFO again, then reset asynchronously mid-cycle.
        wr_ready_i = 1'b0;
        step(); chk_req("f0", 1'b0, 32'h0000_0010); chk_wr("f0", 1'b1, 32'h0000_0008);
        #2 rst_ni = 1'b0;
        #1;
        chk_req("f_async", 1'b0, RST);
        chk_wr("f_async", 1'b0, 32'h0);
        step();
        lat        = 3;
        wr_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        #1;
        chk_req("c_restart", 1'b1, RST);

        // Redirect to 0x103 with two requests in flight (L=3).
        step(); chk_req("c0", 1'b1, 32'hFFFF_FFFC);
        step(); chk_req("c1", 1'b0, 32'h0000_0000); chk_wr("c1", 1'b0, 32'h0);
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0103;
        step();
        redirect_valid_i = 1'b0;
        #1;
        chk_req("c2", 1'b0, 32'h0000_0100); chk_wr("c2", 1'b0, 32'h0);
        step(); chk_req("c3", 1'b1, 32'h0000_0100); chk_wr("c3", 1'b0, 32'h0);
        step(); chk_req("c4", 1'b1, 32'h0000_0104); chk_wr("c4", 1'b0, 32'h0);
        step(); chk_req("c5", 1'b0, 32'h0000_0108); chk_wr("c5", 1'b0, 32'h0);
        step(); chk_req("c6", 1'b0, 32'h0000_0108); chk_wr("c6", 1'b0, 32'h0);
        step(); chk_req("c7", 1'b0, 32'h0000_0108); chk_wr("c7", 1'b1, 32'h0000_0100);
        step(); chk_req("c8", 1'b1, 32'h0000_0108); chk_wr("c8", 1'b1, 32'h0000_0104);

        // Redirect coinciding with a response and a downstream pop.
        step(); chk_req("d0", 1'b1, 32'h0000_010C); chk_wr("d0", 1'b0, 32'h0);
        step(); chk_req("d1", 1'b0, 32'h0000_0110);
        step(); chk_req("d2", 1'b0, 32'h0000_0110); chk_wr("d2", 1'b0, 32'h0);
        step(); chk_req("d3", 1'b0, 32'h0000_0110); chk_wr("d3", 1'b1, 32'h0000_0108);
        pops_ref         = n_pops;
        redirect_valid_i = 1'b1;
        redirect_addr_i  = 32'h0000_0200;
        step();
        redirect_valid_i = 1'b0;
        #1;
        chk("d_pop", 64'(n_pops - pops_ref), 64'd1);
        chk_req("d4", 1'b1, 32'h0000_0200); chk_wr("d4", 1'b0, 32'h0);
        step(); chk_req("d5", 1'b1, 32'h0000_0204);
        step(); chk_req("d6", 1'b0, 32'h0000_0208);
        step(); chk_wr("d7", 1'b0, 32'h0);
        step(); chk_wr("d8", 1'b1, 32'h0000_0200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
